dm_lsu: RTL and testbench

Parametrised data memory with an integrated load/store unit. It replaces the single-cycle word DM in the MEM stage.
- Adds sub-word loads with sign or zero extension, alignment-error detection, a registered read port and a valid/ready request handshake.
- Adds a synthesizable clear-on-reset sequencer that walks the array one word per cycle. It does not clear the whole array in one edge.

---
 rtl/dm_lsu.sv | 174 +++++++++++++++++
 tb/tb_dm_lsu.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_lsu.sv
// Data memory with load/store unit: sub-word loads with extension, alignment checks,
// registered read port, valid/ready request handshake and a word-per-cycle clear sequencer.
module dm_lsu #(
  parameter int DEPTH_LOG2     = 12,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter bit TRACE          = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        align_err,
  output logic        busy
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] clear_ptr_q, clear_ptr_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rdata_valid_q, rdata_valid_d;
  logic                  align_err_q, align_err_d;

  logic [31:0]           mem [WORDS];

  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           old_word;
  logic [31:0]           merged_word;
  logic [31:0]           load_word;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic                  misaligned;
  logic                  accept;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [31:0]           mem_wdata;

  assign word_idx    = addr[DEPTH_LOG2+1:2];
  assign old_word    = mem[word_idx];
  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_CLEAR);
  assign accept      = req_valid && req_ready && !reset;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign align_err   = align_err_q;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = (addr[1:0] != 2'b00);
      2'b01:   misaligned = 1'b0;
      2'b10:   misaligned = addr[0];
      default: misaligned = 1'b1;
    endcase
  end

  // Stores rewrite the whole word: untouched lanes are carried over from the old contents.
  always_comb begin
    merged_word = old_word;
    case (req_size)
      2'b00: merged_word = wdata;
      2'b01: begin
        case (addr[1:0])
          2'b00:   merged_word[7:0]   = wdata[7:0];
          2'b01:   merged_word[15:8]  = wdata[7:0];
          2'b10:   merged_word[23:16] = wdata[7:0];
          default: merged_word[31:24] = wdata[7:0];
        endcase
      end
      2'b10: begin
        if (addr[1]) merged_word[31:16] = wdata[15:0];
        else         merged_word[15:0]  = wdata[15:0];
      end
      default: merged_word = old_word;
    endcase
  end

  always_comb begin
    byte_sel = old_word[7:0];
    case (addr[1:0])
      2'b00:   byte_sel = old_word[7:0];
      2'b01:   byte_sel = old_word[15:8];
      2'b10:   byte_sel = old_word[23:16];
      default: byte_sel = old_word[31:24];
    endcase
    half_sel = addr[1] ? old_word[31:16] : old_word[15:0];

    load_word = old_word;
    case (req_size)
      2'b01:   load_word = req_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b10:   load_word = req_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_word = old_word;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    clear_ptr_d   = clear_ptr_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    align_err_d   = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = word_idx;
    mem_wdata     = merged_word;

    case (state_q)
      ST_CLEAR: begin
        mem_we      = !reset;
        mem_waddr   = clear_ptr_q;
        mem_wdata   = 32'd0;
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept) begin
          if (misaligned) begin
            align_err_d = 1'b1;
          end else if (req_we) begin
            mem_we = 1'b1;
          end else begin
            rdata_d       = load_word;
            rdata_valid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clear_ptr_q   <= '0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      align_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      clear_ptr_q   <= clear_ptr_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      align_err_q   <= align_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

`ifndef SYNTHESIS
  generate
    if (TRACE) begin : g_trace
      always @(posedge clk) begin
        if (accept && req_we && !misaligned)
          $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged_word);
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_dm_lsu.sv
// Bench for dm_lsu: directed scenarios plus random traffic against a byte-addressed memory model.
module tb_dm_lsu;
  localparam int DL = 4;
  localparam int NB = 4 * (1 << DL);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] pc = 32'h0000_1000;
  logic        req_ready;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        align_err;
  logic        busy;

  always #5 clk = ~clk;

  dm_lsu #(.DEPTH_LOG2(DL), .CLEAR_ON_RESET(1'b1), .TRACE(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .addr(addr), .wdata(wdata), .pc(pc), .rdata(rdata),
    .rdata_valid(rdata_valid), .align_err(align_err), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mb [NB];
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_rv = 1'b0;
  logic        exp_ae = 1'b0;

  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4;
      2'b01:   return 1;
      2'b10:   return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic is_bad(input logic [1:0] sz, input logic [31:0] a);
    int n;
    n = nbytes(sz);
    if (n == 0) return 1'b1;
    return (a % n) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    int base;
    int n;
    logic [31:0] v;
    base = int'(a % NB);
    n = nbytes(sz);
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(mb[(base + i) % NB]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NB; i++) mb[i] = 8'h00;
  endtask

  // Drives one request into an IDLE DUT; returns #1 after the accept edge with expectations updated.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
    int base;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    addr = a; wdata = d; pc = pc + 32'd4;
    if (is_bad(sz, a)) begin
      exp_ae = 1'b1; exp_rv = 1'b0;
    end else if (we) begin
      base = int'(a % NB);
      for (int i = 0; i < nbytes(sz); i++) mb[(base + i) % NB] = 8'(d >> (8 * i));
      exp_ae = 1'b0; exp_rv = 1'b0;
    end else begin
      exp_rdata = model_load(sz, uns, a);
      exp_ae = 1'b0; exp_rv = 1'b1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk); reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, req_ready, rdata_valid, align_err, rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_state: busy/ready/rv/ae/rdata got %b%b%b%b %h required 1000 00000000",
               busy, req_ready, rdata_valid, align_err, rdata);
    end
    reset = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    n_checks++;
    if (n != 16 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_length: busy cycles %0d ready %b required 16 and 1", n, req_ready);
    end
    model_clear();
    exp_rdata = 32'd0;
    for (int w = 0; w < 16; w++) begin
      issue(1'b0, 2'b00, 1'b0, 32'(w * 4), 32'd0);
      n_checks++;
      if ({rdata_valid, rdata} !== {1'b1, 32'd0}) begin
        n_fail++;
        $display("FAIL cleared_word%0d: rv %b rdata %h required 1 00000000", w, rdata_valid, rdata);
      end
    end
  endtask

  task automatic test_subword();
    issue(1'b1, 2'b00, 1'b0, 32'h10, 32'h1234_5678);
    n_checks++;
    if ({rdata_valid, align_err} !== 2'b00) begin
      n_fail++; $display("FAIL sw_pulses: rv %b ae %b required 0 0", rdata_valid, align_err);
    end
    issue(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_00AB);
    issue(1'b0, 2'b01, 1'b0, 32'h11, 32'd0);
    n_checks++;
    if ({rdata_valid, rdata} !== {1'b1, 32'hFFFF_FFAB}) begin
      n_fail++; $display("FAIL lb: rv %b rdata %h required 1 ffffffab", rdata_valid, rdata);
    end
    issue(1'b0, 2'b01, 1'b1, 32'h11, 32'd0);
    n_checks++;
    if (rdata !== 32'h0000_00AB) begin
      n_fail++; $display("FAIL lbu: rdata %h required 000000ab", rdata);
    end
    issue(1'b0, 2'b00, 1'b0, 32'h10, 32'd0);
    n_checks++;
    if (rdata !== 32'h1234_AB78) begin
      n_fail++; $display("FAIL sb_merge: rdata %h required 1234ab78", rdata);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rdata_valid !== 1'b0 || rdata !== 32'h1234_AB78) begin
      n_fail++; $display("FAIL rv_pulse: rv %b rdata %h required 0 1234ab78", rdata_valid, rdata);
    end
  endtask

  task automatic test_half();
    issue(1'b1, 2'b10, 1'b0, 32'h22, 32'h0000_8001);
    issue(1'b0, 2'b10, 1'b0, 32'h22, 32'd0);
    n_checks++;
    if ({rdata_valid, rdata} !== {1'b1, 32'hFFFF_8001}) begin
      n_fail++; $display("FAIL lh: rv %b rdata %h required 1 ffff8001", rdata_valid, rdata);
    end
    issue(1'b0, 2'b10, 1'b1, 32'h22, 32'd0);
    n_checks++;
    if (rdata !== 32'h0000_8001) begin
      n_fail++; $display("FAIL lhu: rdata %h required 00008001", rdata);
    end
    issue(1'b0, 2'b00, 1'b0, 32'h20, 32'd0);
    n_checks++;
    if (rdata !== 32'h8001_0000) begin
      n_fail++; $display("FAIL lw_half: rdata %h required 80010000", rdata);
    end
  endtask

  task automatic test_align();
    logic [31:0] bad_a [4];
    logic [1:0]  bad_s [4];
    logic        bad_w [4];
    bad_a = '{32'h21, 32'h22, 32'h20, 32'h23};
    bad_s = '{2'b10, 2'b00, 2'b11, 2'b11};
    bad_w = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      issue(bad_w[k], bad_s[k], 1'b0, bad_a[k], 32'hDEAD_BEEF);
      n_checks++;
      if ({align_err, rdata_valid, rdata} !== {1'b1, 1'b0, exp_rdata}) begin
        n_fail++;
        $display("FAIL align_err%0d: ae %b rv %b rdata %h required 1 0 %h", k, align_err, rdata_valid, rdata, exp_rdata);
      end
      @(posedge clk); #1;
      n_checks++;
      if (align_err !== 1'b0) begin
        n_fail++; $display("FAIL ae_pulse%0d: ae %b required 0", k, align_err);
      end
    end
    issue(1'b0, 2'b00, 1'b0, 32'h20, 32'd0);
    n_checks++;
    if (rdata !== 32'h8001_0000) begin
      n_fail++; $display("FAIL unchanged: rdata %h required 80010000", rdata);
    end
  endtask

  task automatic test_reset_during_clear();
    int n;
    int rv_seen;
    @(negedge clk); reset = 1'b1;
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; addr = 32'h10;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    n = 0; rv_seen = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (rdata_valid !== 1'b0) rv_seen++;
      @(negedge clk);
    end
    n_checks++;
    if (n != 16 || rv_seen != 0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reclear: busy %0d rv_seen %0d ready %b required 16 0 1", n, rv_seen, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    model_clear();
    exp_rdata = 32'd0;
    n_checks++;
    if ({rdata_valid, rdata} !== {1'b1, 32'd0}) begin
      n_fail++; $display("FAIL held_req: rv %b rdata %h required 1 00000000", rdata_valid, rdata);
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 2'b00, 1'b0, 32'h40, 32'hCAFE_F00D);
    issue(1'b0, 2'b00, 1'b0, 32'h00, 32'd0);
    n_checks++;
    if ({rdata_valid, rdata} !== {1'b1, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL wrap: rv %b rdata %h required 1 cafef00d", rdata_valid, rdata);
    end
    issue(1'b1, 2'b00, 1'b0, 32'h00, 32'h1122_3344);
    issue(1'b0, 2'b00, 1'b0, 32'h00, 32'd0);
    n_checks++;
    if ({rdata_valid, rdata} !== {1'b1, 32'h1122_3344}) begin
      n_fail++; $display("FAIL st_then_ld: rv %b rdata %h required 1 11223344", rdata_valid, rdata);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int t = 0; t < 300; t++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & 32'h0000_007F;
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
      n_checks++;
      if ({rdata_valid, align_err, rdata} !== {exp_rv, exp_ae, exp_rdata}) begin
        n_fail++;
        $display("FAIL random%0d: rv/ae/rdata %b %b %h required %b %b %h",
                 t, rdata_valid, align_err, rdata, exp_rv, exp_ae, exp_rdata);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        n_checks++;
        if ({rdata_valid, align_err} !== 2'b00) begin
          n_fail++; $display("FAIL idle%0d: rv %b ae %b required 0 0", t, rdata_valid, align_err);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_subword();
    test_half();
    test_align();
    test_reset_during_clear();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
